elbeth_branch_ctrl: RTL and testbench
=====================================

// Module: elbeth_branch_ctrl
// PURPOSE
//  Sequences ID-stage branch resolution for the elbeth_branch_unit. Detects operand hazards on
//  rs1/rs2 against EX/MEM producers and stalls ID until operands are valid. Then issues the PC
//  redirect plus IF flush with a ready/valid handshake to the fetch stage. Keeps branch counters.
// PARAMETERS
//  REG_ADDR_W  5   register-file address width
//  CNT_WIDTH   32  width of each statistics counter
// PORTS
//  clk             in   1           core clock; all state updates on rising edge
//  rst             in   1           synchronous reset, active-high
//  id_br_valid     in   1           ID holds a valid control-transfer instr
//  id_br_op        in   3           operation code, same encoding as branch unit (OP_*)
//  id_rs1_addr     in   REG_ADDR_W  ID source register 1
//  id_rs2_addr     in   REG_ADDR_W  ID source register 2
//  ex_rd_addr      in   REG_ADDR_W  EX destination; ex_reg_we / ex_mem_read in 1 each
//  mem_rd_addr     in   REG_ADDR_W  MEM destination; mem_reg_we / mem_mem_read in 1 each
//  bu_pc_branch    in   32          target from branch unit
//  bu_taken        in   1           taken flag from branch unit
//  if_ready        in   1           fetch accepts a redirect this cycle
//  redirect_valid  out  1           PC redirect request to fetch
//  redirect_pc     out  32          redirect target
//  if_flush        out  1           kill instr in IF/ID (high only on redirect handshake cycle)
//  id_stall        out  1           hold PC and IF/ID register
//  ex_bubble       out  1           insert NOP into ID/EX
//  br_count / taken_count / stall_count  out  CNT_WIDTH  statistics
// BEHAVIOUR
//  Source use: OP_JAL uses no sources; OP_JALR rs1 only; conditional ops (BEQ..BGEU) rs1+rs2.
//   Other op values: not a branch, no action. Register 0 never causes a hazard.
//  Hazard (combinational, per used source r != 0):
//   ex_reg_we & ex_rd_addr==r (ALU or load); mem_reg_we & mem_mem_read & mem_rd_addr==r.
//   MEM-stage ALU results are forwarded into ID elsewhere and cause no hazard.
//  FSM states: RUN, HAZARD, HOLD (encodings in shared definitions file).
//   RUN: id_br_valid & hazard -> HAZARD; id_stall=1, ex_bubble=1, no redirect.
//        id_br_valid & ~hazard & bu_taken & if_ready -> redirect_valid=1, redirect_pc=bu_pc_branch,
//          if_flush=1, stay RUN (zero-cycle latency, same cycle as resolution).
//        id_br_valid & ~hazard & bu_taken & ~if_ready -> latch bu_pc_branch into hold_pc, go HOLD;
//          redirect_valid=1 this cycle, id_stall=1, ex_bubble=0 (branch proceeds to EX).
//        id_br_valid & ~hazard & ~bu_taken -> no action.
//   HAZARD: hazard re-evaluated every cycle; stays while hazard (id_stall=1, ex_bubble=1);
//        hazard clear -> resolve exactly as RUN in same cycle, next state RUN or HOLD.
//        id_br_valid low in HAZARD (upstream kill) -> RUN, no redirect.
//   HOLD: redirect_valid=1, redirect_pc=hold_pc, id_stall=1, ex_bubble=1; ID inputs ignored;
//        if_ready -> if_flush=1, -> RUN. hold_pc never changes while in HOLD.
//  Priority: rst > HOLD handshake > hazard > taken.
//  Counters (increment on cycle edge, wrap modulo 2^CNT_WIDTH, no saturation):
//   br_count +1 per resolved branch (non-hazard cycle with id_br_valid in RUN/HAZARD);
//   taken_count +1 per resolved taken branch; stall_count +1 per cycle with id_stall=1.
//  Reset: state=RUN, hold_pc=0, all counters 0; outputs redirect_valid/if_flush/id_stall/
//   ex_bubble=0, redirect_pc=0 during and after reset until inputs drive otherwise.
//   Reset in HAZARD or HOLD abandons pending redirect; no flush issued.
//  redirect_pc = 0 whenever redirect_valid=0 (no X propagation).
// STRUCTURE
//  Shared definitions file: OP_* codes (already there), add BRC_RUN/BRC_HAZARD/BRC_HOLD.
//  Sub-module elbeth_branch_hazard_detect: combinational source-use decode + hazard compare.
//  Top: FSM, hold_pc register, counters, output muxing.
// TESTING
//  BEQ, no hazard, bu_taken=1, if_ready=1, target 0x100 -> same cycle redirect_valid=1,
//   redirect_pc=0x100, if_flush=1; br_count=1, taken_count=1.
//  BNE rs1=5, EX load rd=5 then MEM load rd=5 -> 2 cycles id_stall=ex_bubble=1,
//   resolve in 3rd cycle; stall_count=2.
//  JALR taken with if_ready=0 for 3 cycles, target 0x2000 -> redirect_valid held 4 cycles with
//   0x2000 while bu_pc_branch changes; if_flush only in 4th (handshake) cycle.
//  BLT with rs2=0 and EX rd=0 we=1 -> no stall; JAL with EX rd=rs1 -> no stall.
//  rst asserted in HOLD -> next cycle state RUN, redirect_valid=0, counters 0, no if_flush.
//  CNT_WIDTH=4, 17 resolved branches -> br_count wraps to 1.

Source files
------------

// File: rtl/elbeth_branch_ctrl_pkg.sv
// Shared definitions for the elbeth branch unit and its ID-stage controller.
// Holds the branch op encoding, controller state encodings and the source-use decode helper.
package elbeth_branch_ctrl_pkg;

  localparam int unsigned OP_W = 3;

  // Branch unit operation codes (conditional codes follow the RV32 funct3 layout)
  localparam logic [OP_W-1:0] OP_BEQ  = 3'b000;
  localparam logic [OP_W-1:0] OP_BNE  = 3'b001;
  localparam logic [OP_W-1:0] OP_JAL  = 3'b010;
  localparam logic [OP_W-1:0] OP_JALR = 3'b011;
  localparam logic [OP_W-1:0] OP_BLT  = 3'b100;
  localparam logic [OP_W-1:0] OP_BGE  = 3'b101;
  localparam logic [OP_W-1:0] OP_BLTU = 3'b110;
  localparam logic [OP_W-1:0] OP_BGEU = 3'b111;

  typedef enum logic [1:0] {
    BRC_RUN    = 2'd0,
    BRC_HAZARD = 2'd1,
    BRC_HOLD   = 2'd2
  } brc_state_e;

  typedef struct packed {
    logic is_branch;
    logic use_rs1;
    logic use_rs2;
  } src_use_t;

  // Which register sources an op reads; unknown ops are not branches
  function automatic src_use_t decode_src(input logic [OP_W-1:0] op);
    src_use_t u;
    u = '0;
    case (op)
      OP_JAL:  u.is_branch = 1'b1;
      OP_JALR: begin
        u.is_branch = 1'b1;
        u.use_rs1   = 1'b1;
      end
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
        u.is_branch = 1'b1;
        u.use_rs1   = 1'b1;
        u.use_rs2   = 1'b1;
      end
      default: u = '0;
    endcase
    return u;
  endfunction

endpackage

// File: rtl/elbeth_branch_hazard_detect.sv
// Combinational operand-hazard check for the branch in ID.
// Ports: op/rs1_addr/rs2_addr from ID; ex_* and mem_* producer info;
//        is_branch_c (op is a control transfer), hazard_c (a used source is not yet available).
module elbeth_branch_hazard_detect #(
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic [2:0]            op,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  input  logic [REG_ADDR_W-1:0] ex_rd_addr,
  input  logic                  ex_reg_we,
  input  logic [REG_ADDR_W-1:0] mem_rd_addr,
  input  logic                  mem_reg_we,
  input  logic                  mem_mem_read,
  output logic                  is_branch_c,
  output logic                  hazard_c
);
  import elbeth_branch_ctrl_pkg::*;

  src_use_t use_c;
  logic     rs1_hz_c;
  logic     rs2_hz_c;

  // Any EX writer blocks; in MEM only a load does, ALU results are forwarded into ID
  always_comb begin
    use_c    = decode_src(op);
    rs1_hz_c = use_c.use_rs1 && (rs1_addr != '0) &&
               ((ex_reg_we && (ex_rd_addr == rs1_addr)) ||
                (mem_reg_we && mem_mem_read && (mem_rd_addr == rs1_addr)));
    rs2_hz_c = use_c.use_rs2 && (rs2_addr != '0) &&
               ((ex_reg_we && (ex_rd_addr == rs2_addr)) ||
                (mem_reg_we && mem_mem_read && (mem_rd_addr == rs2_addr)));
    is_branch_c = use_c.is_branch;
    hazard_c    = rs1_hz_c || rs2_hz_c;
  end

endmodule

// File: rtl/elbeth_branch_ctrl.sv
// ID-stage branch resolution sequencer: stalls on operand hazards, then issues the PC
// redirect and IF flush to fetch with a ready/valid handshake; keeps branch statistics.
// Ports: clk, rst (sync, active-high); id_* branch in ID; ex_*/mem_* producers;
//        bu_pc_branch/bu_taken from branch unit; if_ready from fetch;
//        redirect_valid/redirect_pc/if_flush/id_stall/ex_bubble pipeline control (same-cycle);
//        br_count/taken_count/stall_count statistics.
module elbeth_branch_ctrl #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_br_valid,
  input  logic [2:0]            id_br_op,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr,
  input  logic [REG_ADDR_W-1:0] ex_rd_addr,
  input  logic                  ex_reg_we,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] mem_rd_addr,
  input  logic                  mem_reg_we,
  input  logic                  mem_mem_read,
  input  logic [31:0]           bu_pc_branch,
  input  logic                  bu_taken,
  input  logic                  if_ready,
  output logic                  redirect_valid,
  output logic [31:0]           redirect_pc,
  output logic                  if_flush,
  output logic                  id_stall,
  output logic                  ex_bubble,
  output logic [CNT_WIDTH-1:0]  br_count,
  output logic [CNT_WIDTH-1:0]  taken_count,
  output logic [CNT_WIDTH-1:0]  stall_count
);
  import elbeth_branch_ctrl_pkg::*;

  brc_state_e           state_q, state_d;
  logic [31:0]          hold_pc_q, hold_pc_d;
  logic [CNT_WIDTH-1:0] br_count_q, br_count_d;
  logic [CNT_WIDTH-1:0] taken_count_q, taken_count_d;
  logic [CNT_WIDTH-1:0] stall_count_q, stall_count_d;

  logic is_branch_c;
  logic hazard_c;
  logic br_act_c;
  logic resolved_c;
  logic taken_c;

  // An EX load is already covered by ex_reg_we
  logic unused_ex_mem_read;
  assign unused_ex_mem_read = ex_mem_read;

  elbeth_branch_hazard_detect #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_hazard (
    .op           (id_br_op),
    .rs1_addr     (id_rs1_addr),
    .rs2_addr     (id_rs2_addr),
    .ex_rd_addr   (ex_rd_addr),
    .ex_reg_we    (ex_reg_we),
    .mem_rd_addr  (mem_rd_addr),
    .mem_reg_we   (mem_reg_we),
    .mem_mem_read (mem_mem_read),
    .is_branch_c  (is_branch_c),
    .hazard_c     (hazard_c)
  );

  assign br_act_c = id_br_valid && is_branch_c;

  // State, held target and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= BRC_RUN;
      hold_pc_q     <= '0;
      br_count_q    <= '0;
      taken_count_q <= '0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      hold_pc_q     <= hold_pc_d;
      br_count_q    <= br_count_d;
      taken_count_q <= taken_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  // Next state and same-cycle pipeline control; reset masks everything
  always_comb begin
    state_d        = state_q;
    hold_pc_d      = hold_pc_q;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    if_flush       = 1'b0;
    id_stall       = 1'b0;
    ex_bubble      = 1'b0;
    resolved_c     = 1'b0;
    taken_c        = 1'b0;
    if (!rst) begin
      case (state_q)
        BRC_RUN, BRC_HAZARD: begin
          if (!br_act_c) begin
            state_d = BRC_RUN;
          end else if (hazard_c) begin
            state_d   = BRC_HAZARD;
            id_stall  = 1'b1;
            ex_bubble = 1'b1;
          end else begin
            resolved_c = 1'b1;
            state_d    = BRC_RUN;
            if (bu_taken) begin
              taken_c        = 1'b1;
              redirect_valid = 1'b1;
              redirect_pc    = bu_pc_branch;
              if (if_ready) begin
                if_flush = 1'b1;
              end else begin
                // Fetch busy: park the target, branch itself still moves on to EX
                hold_pc_d = bu_pc_branch;
                state_d   = BRC_HOLD;
                id_stall  = 1'b1;
              end
            end
          end
        end
        BRC_HOLD: begin
          redirect_valid = 1'b1;
          redirect_pc    = hold_pc_q;
          id_stall       = 1'b1;
          ex_bubble      = 1'b1;
          if (if_ready) begin
            if_flush = 1'b1;
            state_d  = BRC_RUN;
          end
        end
        default: state_d = BRC_RUN;
      endcase
    end
  end

  // Free-running statistics, wrap on overflow
  always_comb begin
    br_count_d    = br_count_q + CNT_WIDTH'(resolved_c);
    taken_count_d = taken_count_q + CNT_WIDTH'(taken_c);
    stall_count_d = stall_count_q + CNT_WIDTH'(id_stall);
  end

  assign br_count    = br_count_q;
  assign taken_count = taken_count_q;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_elbeth_branch_ctrl.sv
// Scoreboard bench for elbeth_branch_ctrl (counters built 4 bits wide to exercise wrap).
module tb_elbeth_branch_ctrl;
  import elbeth_branch_ctrl_pkg::*;

  localparam int unsigned CW = 4;

  logic          clk;
  logic          rst;
  logic          id_br_valid;
  logic [2:0]    id_br_op;
  logic [4:0]    id_rs1_addr, id_rs2_addr, ex_rd_addr, mem_rd_addr;
  logic          ex_reg_we, ex_mem_read, mem_reg_we, mem_mem_read;
  logic [31:0]   bu_pc_branch;
  logic          bu_taken, if_ready;
  logic          redirect_valid, if_flush, id_stall, ex_bubble;
  logic [31:0]   redirect_pc;
  logic [CW-1:0] br_count, taken_count, stall_count;

  elbeth_branch_ctrl #(.REG_ADDR_W(5), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .id_br_valid(id_br_valid), .id_br_op(id_br_op),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .ex_rd_addr(ex_rd_addr), .ex_reg_we(ex_reg_we), .ex_mem_read(ex_mem_read),
    .mem_rd_addr(mem_rd_addr), .mem_reg_we(mem_reg_we), .mem_mem_read(mem_mem_read),
    .bu_pc_branch(bu_pc_branch), .bu_taken(bu_taken), .if_ready(if_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .if_flush(if_flush),
    .id_stall(id_stall), .ex_bubble(ex_bubble),
    .br_count(br_count), .taken_count(taken_count), .stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [3:0]  flags;   // {redirect_valid, if_flush, id_stall, ex_bubble}
    logic [31:0] pc;
    logic        rst_cyc;
    logic        res;
    logic        tk;
  } exp_t;

  exp_t          sb_q[$];
  int            n_cmp = 0;
  int            n_err = 0;
  logic [CW-1:0] m_br = '0, m_tk = '0, m_st = '0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Drive one cycle at negedge, push expectation, check same-cycle outputs then counters
  task automatic cyc(input string nm, input logic r, input logic v, input logic [2:0] op,
                     input logic [4:0] s1, input logic [4:0] s2,
                     input logic [4:0] xrd, input logic xwe, input logic xmr,
                     input logic [4:0] mrd, input logic mwe, input logic mmr,
                     input logic [31:0] tgt, input logic tk, input logic rdy,
                     input logic [3:0] e_flags, input logic [31:0] e_pc,
                     input logic e_res, input logic e_tk);
    exp_t e;
    @(negedge clk);
    rst = r; id_br_valid = v; id_br_op = op; id_rs1_addr = s1; id_rs2_addr = s2;
    ex_rd_addr = xrd; ex_reg_we = xwe; ex_mem_read = xmr;
    mem_rd_addr = mrd; mem_reg_we = mwe; mem_mem_read = mmr;
    bu_pc_branch = tgt; bu_taken = tk; if_ready = rdy;
    sb_q.push_back('{nm: nm, flags: e_flags, pc: e_pc, rst_cyc: r, res: e_res, tk: e_tk});
    #2;
    if (sb_q.size() == 0) begin
      check_val({nm, ".sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check_val({e.nm, ".flags"}, 32'({redirect_valid, if_flush, id_stall, ex_bubble}),
                32'(e.flags));
      check_val({e.nm, ".redirect_pc"}, redirect_pc, e.pc);
      @(posedge clk);
      #1;
      if (e.rst_cyc) begin
        m_br = '0; m_tk = '0; m_st = '0;
      end else begin
        m_br = m_br + CW'(e.res);
        m_tk = m_tk + CW'(e.tk);
        m_st = m_st + CW'(e.flags[1]);
      end
      check_val({e.nm, ".br_count"}, 32'(br_count), 32'(m_br));
      check_val({e.nm, ".taken_count"}, 32'(taken_count), 32'(m_tk));
      check_val({e.nm, ".stall_count"}, 32'(stall_count), 32'(m_st));
    end
  endtask

  initial begin
    rst = 1'b1; id_br_valid = 1'b0; id_br_op = '0; id_rs1_addr = '0; id_rs2_addr = '0;
    ex_rd_addr = '0; ex_reg_we = 1'b0; ex_mem_read = 1'b0; mem_rd_addr = '0;
    mem_reg_we = 1'b0; mem_mem_read = 1'b0; bu_pc_branch = '0; bu_taken = 1'b0; if_ready = 1'b1;

    // Reset, including a taken branch presented during reset
    cyc("rst0", 1, 0, OP_BEQ, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 1, 4'b0000, 32'h0, 0, 0);
    cyc("rst1", 1, 1, OP_BEQ, 1, 2, 0, 0, 0, 0, 0, 0, 32'h55, 1, 1, 4'b0000, 32'h0, 0, 0);

    // BEQ no hazard, taken, fetch ready: same-cycle redirect + flush
    cyc("beq", 0, 1, OP_BEQ, 1, 2, 0, 0, 0, 0, 0, 0, 32'h100, 1, 1, 4'b1100, 32'h100, 1, 1);

    // BNE rs1=5: EX load, then MEM load, then resolves taken
    cyc("bne_ex", 0, 1, OP_BNE, 5, 6, 5, 1, 1, 0, 0, 0, 32'h300, 1, 1, 4'b0011, 32'h0, 0, 0);
    cyc("bne_mem", 0, 1, OP_BNE, 5, 6, 0, 0, 0, 5, 1, 1, 32'h300, 1, 1, 4'b0011, 32'h0, 0, 0);
    cyc("bne_res", 0, 1, OP_BNE, 5, 6, 0, 0, 0, 0, 0, 0, 32'h300, 1, 1, 4'b1100, 32'h300, 1, 1);

    // JALR taken, fetch busy 3 cycles; held target survives changing bu_pc_branch
    cyc("jalr_0", 0, 1, OP_JALR, 7, 0, 7, 0, 0, 0, 0, 0, 32'h2000, 1, 0, 4'b1010, 32'h2000, 1, 1);
    cyc("jalr_1", 0, 1, OP_JALR, 7, 0, 7, 1, 0, 0, 0, 0, 32'h3000, 1, 0, 4'b1011, 32'h2000, 0, 0);
    cyc("jalr_2", 0, 1, OP_BEQ, 7, 0, 0, 0, 0, 0, 0, 0, 32'h4000, 0, 0, 4'b1011, 32'h2000, 0, 0);
    cyc("jalr_3", 0, 1, OP_BEQ, 1, 2, 0, 0, 0, 0, 0, 0, 32'h5000, 1, 1, 4'b1111, 32'h2000, 0, 0);

    // Register 0 and MEM ALU producers never stall; JAL reads no sources
    cyc("blt_x0", 0, 1, OP_BLT, 3, 0, 0, 1, 0, 0, 0, 0, 32'h111, 0, 1, 4'b0000, 32'h0, 1, 0);
    cyc("bge_fwd", 0, 1, OP_BGE, 9, 10, 0, 0, 0, 10, 1, 0, 32'h400, 1, 1, 4'b1100, 32'h400, 1, 1);
    cyc("jal", 0, 1, OP_JAL, 8, 8, 8, 1, 1, 8, 1, 1, 32'h800, 1, 1, 4'b1100, 32'h800, 1, 1);

    // Hazard then upstream kill returns to RUN without redirect
    cyc("kill_hz", 0, 1, OP_BEQ, 1, 4, 0, 0, 0, 4, 1, 1, 32'h600, 1, 1, 4'b0011, 32'h0, 0, 0);
    cyc("kill", 0, 0, OP_BEQ, 1, 4, 0, 0, 0, 4, 1, 1, 32'h600, 1, 1, 4'b0000, 32'h0, 0, 0);
    cyc("after_kill", 0, 1, OP_BEQ, 1, 2, 0, 0, 0, 0, 0, 0, 32'h610, 0, 1, 4'b0000, 32'h0, 1, 0);

    // Hazard clears into a busy fetch: HAZARD -> HOLD -> RUN
    cyc("bgeu_hz", 0, 1, OP_BGEU, 11, 12, 11, 1, 0, 0, 0, 0, 32'h900, 1, 0, 4'b0011, 32'h0, 0, 0);
    cyc("bgeu_res", 0, 1, OP_BGEU, 11, 12, 0, 0, 0, 0, 0, 0, 32'h900, 1, 0, 4'b1010, 32'h900, 1, 1);
    cyc("bgeu_hs", 0, 0, OP_BEQ, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 1, 4'b1111, 32'h900, 0, 0);

    // Reset while holding abandons the redirect, no flush
    cyc("hold_pre", 0, 1, OP_BEQ, 1, 2, 0, 0, 0, 0, 0, 0, 32'hA00, 1, 0, 4'b1010, 32'hA00, 1, 1);
    cyc("hold_rst", 1, 0, OP_BEQ, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 1, 4'b0000, 32'h0, 0, 0);
    cyc("post_rst", 0, 0, OP_BEQ, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 1, 4'b0000, 32'h0, 0, 0);

    // 17 resolved branches wrap a 4-bit br_count to 1
    for (int i = 0; i < 17; i++) begin
      cyc("wrap", 0, 1, OP_BNE, 1, 2, 0, 0, 0, 0, 0, 0, 32'h0, 0, 1, 4'b0000, 32'h0, 1, 0);
    end
    check_val("br_wrap", 32'(br_count), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
